// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Resolves one RV32I conditional branch at a time around a shared, external
// comparator. A request is captured in IDLE, evaluated in EVAL (one cycle),
// and on a mispredict the controller issues a one-cycle PC redirect followed
// by FLUSH_CYCLES cycles of pipeline flush. Saturating taken/mispredict
// counters are kept for performance monitoring.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   br_valid_i/ready_o  request handshake
//   br_funct3_i         branch condition
//   br_pc_i, br_imm_i   branch PC and sign-extended B-type immediate
//   br_pred_taken_i     front-end static prediction
//   rs1_data_i/rs2_data_i  operands
//   cmp_rs1_o/cmp_rs2_o/cmp_unsign_o  operands and mode to the comparator
//   cmp_less_i/cmp_equal_i            comparator results (combinational)
//   redirect_valid_o/redirect_pc_o    one-cycle redirect strobe and target
//   flush_o             kill younger instructions
//   illegal_o           one-cycle strobe on unsupported funct3
//   taken_cnt_o/mispred_cnt_o         saturating performance counters
// -----------------------------------------------------------------------------
module branch_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid_i,
   output logic             br_ready_o,
   input  logic [2:0]       br_funct3_i,
   input  logic [31:0]      br_pc_i,
   input  logic [31:0]      br_imm_i,
   input  logic             br_pred_taken_i,
   input  logic [31:0]      rs1_data_i,
   input  logic [31:0]      rs2_data_i,
   output logic [31:0]      cmp_rs1_o,
   output logic [31:0]      cmp_rs2_o,
   output logic             cmp_unsign_o,
   input  logic             cmp_less_i,
   input  logic             cmp_equal_i,
   output logic             redirect_valid_o,
   output logic [31:0]      redirect_pc_o,
   output logic             flush_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] taken_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   // A zero-length flush still needs a legal (1-bit) counter vector.
   localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
   localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EVAL  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [2:0]        r_funct3;
   logic [31:0]       r_pc;
   logic [31:0]       r_imm;
   logic              r_pred;
   logic [31:0]       r_rs1;
   logic [31:0]       r_rs2;
   logic [31:0]       r_redir_pc;
   logic [CNT_W-1:0]  r_taken_cnt;
   logic [CNT_W-1:0]  r_mispred_cnt;
   logic [FC_W-1:0]   r_flush_cnt;

   logic              w_accept;
   logic              w_eval;
   logic              w_illegal;
   logic              w_taken;
   logic              w_mispred;
   logic [31:0]       w_target;

   // funct3 010/011 are not conditional branches in RV32I.
   function automatic logic f_is_illegal(input logic [2:0] funct3);
      return (funct3[2:1] == 2'b01);
   endfunction

   // Map comparator results onto the branch condition.
   function automatic logic f_decode_taken(input logic [2:0] funct3,
                                           input logic       less,
                                           input logic       equal);
      logic taken;
      case (funct3)
         3'b000:  taken = equal;
         3'b001:  taken = ~equal;
         3'b100:  taken = less;
         3'b110:  taken = less;
         3'b101:  taken = ~less;
         3'b111:  taken = ~less;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : (v + {{(CNT_W-1){1'b0}}, 1'b1});
   endfunction

   // Next-state and EVAL-cycle outcome decode.
   always_comb begin
      w_state_nxt = r_state;
      w_illegal   = 1'b0;
      w_taken     = 1'b0;
      w_mispred   = 1'b0;
      w_target    = r_pc + 32'd4;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_EVAL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_EVAL: begin
            w_illegal = f_is_illegal(r_funct3);
            // Illegal encodings resolve as not-taken and correctly predicted.
            w_taken   = ~w_illegal & f_decode_taken(r_funct3, cmp_less_i, cmp_equal_i);
            w_mispred = ~w_illegal & (w_taken ^ r_pred);
            if (w_taken) begin
               w_target = r_pc + r_imm;
            end else begin
               w_target = r_pc + 32'd4;
            end
            if (w_mispred && (FLUSH_CYCLES > 0)) begin
               w_state_nxt = S_FLUSH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt <= FC_ONE) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_FLUSH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Handshake and strobes; reset suppresses them so a pending redirect is dropped.
   assign br_ready_o       = (r_state == S_IDLE) & ~rst;
   assign w_accept         = br_valid_i & br_ready_o;
   assign w_eval           = (r_state == S_EVAL) & ~rst;
   assign redirect_valid_o = w_eval & w_mispred;
   assign illegal_o        = w_eval & w_illegal;
   assign redirect_pc_o    = redirect_valid_o ? w_target : r_redir_pc;
   assign flush_o          = (r_state == S_FLUSH);
   assign cmp_rs1_o        = r_rs1;
   assign cmp_rs2_o        = r_rs2;
   assign cmp_unsign_o     = r_funct3[1];
   assign taken_cnt_o      = r_taken_cnt;
   assign mispred_cnt_o    = r_mispred_cnt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request capture; these registers alone feed the comparator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_funct3 <= 3'd0;
         r_pc     <= 32'd0;
         r_imm    <= 32'd0;
         r_pred   <= 1'b0;
         r_rs1    <= 32'd0;
         r_rs2    <= 32'd0;
      end else if (w_accept) begin
         r_funct3 <= br_funct3_i;
         r_pc     <= br_pc_i;
         r_imm    <= br_imm_i;
         r_pred   <= br_pred_taken_i;
         r_rs1    <= rs1_data_i;
         r_rs2    <= rs2_data_i;
      end
   end

   // Remember the last redirect target so redirect_pc_o holds between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_redir_pc <= 32'd0;
      end else if (redirect_valid_o) begin
         r_redir_pc <= w_target;
      end
   end

   // Flush length down-counter, loaded as EVAL hands over to FLUSH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush_cnt <= '0;
      end else if (w_eval && w_mispred) begin
         r_flush_cnt <= FC_LOAD;
      end else if ((r_state == S_FLUSH) && (r_flush_cnt != '0)) begin
         r_flush_cnt <= r_flush_cnt - FC_ONE;
      end
   end

   // Saturating performance counters, updated only on the EVAL cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_taken_cnt   <= '0;
         r_mispred_cnt <= '0;
      end else if (w_eval) begin
         if (w_taken) begin
            r_taken_cnt <= f_sat_inc(r_taken_cnt);
         end
         if (w_mispred) begin
            r_mispred_cnt <= f_sat_inc(r_mispred_cnt);
         end
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Directed scoreboard bench for branch_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// The stimulus process pushes hand-computed expectations; an independent
// monitor pops one per accepted request and compares the EVAL outcome, the
// counters and the flush window. A small comparator model closes the loop.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;

   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 4;
   localparam int CNT_MAX      = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             br_valid_i = 1'b0;
   logic             br_ready_o;
   logic [2:0]       br_funct3_i = 3'd0;
   logic [31:0]      br_pc_i = 32'd0;
   logic [31:0]      br_imm_i = 32'd0;
   logic             br_pred_taken_i = 1'b0;
   logic [31:0]      rs1_data_i = 32'd0;
   logic [31:0]      rs2_data_i = 32'd0;
   logic [31:0]      cmp_rs1_o;
   logic [31:0]      cmp_rs2_o;
   logic             cmp_unsign_o;
   logic             cmp_less_i;
   logic             cmp_equal_i;
   logic             redirect_valid_o;
   logic [31:0]      redirect_pc_o;
   logic             flush_o;
   logic             illegal_o;
   logic [CNT_W-1:0] taken_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int exp_tc   = 0;
   int exp_mc   = 0;
   logic [31:0] last_rpc = 32'd0;

   typedef struct {
      logic        rv;
      logic [31:0] pc;
      logic        ill;
      logic        uns;
      logic        mis;
      logic        abort;
      int          tc;
      int          mc;
   } exp_t;

   exp_t q[$];

   branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
      .br_funct3_i(br_funct3_i), .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
      .br_pred_taken_i(br_pred_taken_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .cmp_rs1_o(cmp_rs1_o), .cmp_rs2_o(cmp_rs2_o), .cmp_unsign_o(cmp_unsign_o),
      .cmp_less_i(cmp_less_i), .cmp_equal_i(cmp_equal_i),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .flush_o(flush_o), .illegal_o(illegal_o),
      .taken_cnt_o(taken_cnt_o), .mispred_cnt_o(mispred_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shared comparator model
   always_comb begin
      cmp_equal_i = (cmp_rs1_o == cmp_rs2_o);
      if (cmp_unsign_o) cmp_less_i = (cmp_rs1_o < cmp_rs2_o);
      else              cmp_less_i = ($signed(cmp_rs1_o) < $signed(cmp_rs2_o));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      br_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("ready_in_reset", {31'd0, br_ready_o}, 32'd0);
      rst = 1'b0;
      exp_tc = 0;
      exp_mc = 0;
      last_rpc = 32'd0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, br_ready_o}, 32'd1);
      chk("flush_after_reset", {31'd0, flush_o}, 32'd0);
      chk("taken_cnt_after_reset", {28'd0, taken_cnt_o}, 32'd0);
      chk("mispred_cnt_after_reset", {28'd0, mispred_cnt_o}, 32'd0);
      chk("redirect_pc_after_reset", redirect_pc_o, 32'd0);
   endtask

   // Push the expectation, then present the request until it is accepted.
   task automatic send(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                       input logic taken, input logic [31:0] target, input logic abort,
                       output int acc_cyc);
      exp_t e;
      int   n;
      e.ill   = (f3[2:1] == 2'b01);
      e.mis   = !e.ill && (taken ^ pred);
      e.rv    = e.mis;
      e.pc    = target;
      e.uns   = f3[1];
      e.abort = abort;
      if (!e.ill && taken && exp_tc < CNT_MAX) exp_tc++;
      if (e.mis && exp_mc < CNT_MAX) exp_mc++;
      e.tc = exp_tc;
      e.mc = exp_mc;
      q.push_back(e);
      @(negedge clk);
      br_funct3_i = f3; br_pc_i = pc; br_imm_i = imm;
      rs1_data_i = rs1; rs2_data_i = rs2; br_pred_taken_i = pred;
      br_valid_i = 1'b1;
      n = 0;
      while (!br_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!br_ready_o) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not_ready expected=ready (t=%0t)", $time);
      end
      @(posedge clk);
      acc_cyc = cyc;
   endtask

   // Monitor: one expectation per accepted request
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (!rst && br_valid_i && br_ready_o) begin
            @(negedge clk);
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_underflow actual=accept expected=no_accept (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, e.rv});
               if (e.rv) begin
                  chk("redirect_pc", redirect_pc_o, e.pc);
                  last_rpc = e.pc;
               end else begin
                  chk("redirect_pc_hold", redirect_pc_o, last_rpc);
               end
               chk("illegal", {31'd0, illegal_o}, {31'd0, e.ill});
               chk("cmp_unsign", {31'd0, cmp_unsign_o}, {31'd0, e.uns});
               chk("ready_in_eval", {31'd0, br_ready_o}, 32'd0);
               chk("flush_in_eval", {31'd0, flush_o}, 32'd0);
               @(negedge clk);
               chk("taken_cnt", {28'd0, taken_cnt_o}, e.tc);
               chk("mispred_cnt", {28'd0, mispred_cnt_o}, e.mc);
               chk("flush_after_eval", {31'd0, flush_o}, {31'd0, e.mis});
               chk("ready_after_eval", {31'd0, br_ready_o}, {31'd0, !e.mis});
               chk("illegal_one_cycle", {31'd0, illegal_o}, 32'd0);
               chk("redirect_one_cycle", {31'd0, redirect_valid_o}, 32'd0);
               if (e.mis && !e.abort) begin
                  @(negedge clk);
                  chk("flush_second_cycle", {31'd0, flush_o}, 32'd1);
                  chk("ready_in_flush", {31'd0, br_ready_o}, 32'd0);
                  @(negedge clk);
                  chk("flush_end", {31'd0, flush_o}, 32'd0);
                  chk("ready_after_flush", {31'd0, br_ready_o}, 32'd1);
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      int acc;
      int prev;
      do_reset();

      // f3      pc            imm           rs1           rs2           pred  taken target        abort
      send(3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0120, 1'b0, acc); // BEQ mispred
      send(3'b100, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0240, 1'b0, acc); // BLT taken ok
      send(3'b110, 32'hFFFF_FFFC, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, acc); // BLTU wrap
      send(3'b010, 32'h0000_0300, 32'h0000_0010, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0304, 1'b0, acc); // illegal
      send(3'b001, 32'h0000_0400, 32'hFFFF_FFF0, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1, 32'h0000_03F0, 1'b0, acc); // BNE back
      send(3'b101, 32'h0000_0500, 32'h0000_0008, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0504, 1'b0, acc); // BGE signed
      send(3'b111, 32'h0000_0600, 32'h0000_0008, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0608, 1'b0, acc); // BGEU
      send(3'b000, 32'h0000_0700, 32'h0000_0008, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0704, 1'b0, acc); // BEQ nt ok
      send(3'b011, 32'h0000_0800, 32'h0000_0008, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0804, 1'b0, acc); // illegal
      @(negedge clk);
      br_valid_i = 1'b0;
      repeat (4) @(negedge clk);

      // Saturation: 20 taken-correct BEQs back-to-back
      do_reset();
      prev = 0;
      for (int i = 0; i < 20; i++) begin
         send(3'b000, 32'h0000_1000 + 32'(i * 4), 32'h0000_0008, 32'(i), 32'(i), 1'b1, 1'b1,
              32'h0000_1008 + 32'(i * 4), 1'b0, acc);
         if (i > 0) chk("accept_spacing", 32'(acc - prev), 32'd2);
         prev = acc;
      end
      @(negedge clk);
      br_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("taken_cnt_saturated", {28'd0, taken_cnt_o}, 32'd15);
      chk("mispred_cnt_zero", {28'd0, mispred_cnt_o}, 32'd0);

      // Reset during the first FLUSH cycle
      send(3'b000, 32'h0000_2000, 32'h0000_0100, 32'h0000_0042, 32'h0000_0042, 1'b0, 1'b1, 32'h0000_2100, 1'b1, acc);
      @(negedge clk);
      br_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_flush_dropped", {31'd0, flush_o}, 32'd0);
      chk("rst_taken_cnt", {28'd0, taken_cnt_o}, 32'd0);
      chk("rst_mispred_cnt", {28'd0, mispred_cnt_o}, 32'd0);
      chk("rst_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
      chk("rst_ready_low", {31'd0, br_ready_o}, 32'd0);
      rst = 1'b0;
      exp_tc = 0;
      exp_mc = 0;
      last_rpc = 32'd0;
      #1;
      chk("rst_ready_release", {31'd0, br_ready_o}, 32'd1);
      @(negedge clk);
      chk("rst_idle_ready", {31'd0, br_ready_o}, 32'd1);
      chk("rst_idle_flush", {31'd0, flush_o}, 32'd0);

      repeat (6) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
